// File: rtl/vc_credit_sender.sv
// Sender side of a credit-based link: per-VC credit counters, packet-state tracking,
// and a one-cycle registered stage onto the link.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module vc_credit_sender #(
  parameter int NUM_VCS      = 4,
  parameter int BUFFER_DEPTH = 8,
  parameter int DATA_WIDTH   = `FLIT_DATA_WIDTH,
  parameter int VC_ID_WIDTH  = $clog2(NUM_VCS),
  parameter int CREDIT_WIDTH = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [VC_ID_WIDTH-1:0]          in_vc,
  input  logic                            in_head,
  input  logic                            in_tail,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  input  logic                            credit_valid,
  input  logic [VC_ID_WIDTH-1:0]          credit_vc,
  output logic                            out_valid,
  output logic [VC_ID_WIDTH-1:0]          out_vc,
  output logic                            out_head,
  output logic                            out_tail,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [NUM_VCS*CREDIT_WIDTH-1:0] credits,
  output logic [NUM_VCS-1:0]              vc_busy,
  output logic                            err_overflow,
  output logic                            err_protocol
);

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(BUFFER_DEPTH);

  logic [CREDIT_WIDTH-1:0] cnt      [NUM_VCS];
  logic [CREDIT_WIDTH-1:0] cnt_nxt  [NUM_VCS];
  vc_state_t               state    [NUM_VCS];
  vc_state_t               state_nxt[NUM_VCS];
  logic [NUM_VCS-1:0]      ovf_hit;
  logic [NUM_VCS-1:0]      perr_hit;
  logic                    accept;

  logic                    vld_p1;
  logic [VC_ID_WIDTH-1:0]  vc_p1;
  logic                    head_p1;
  logic                    tail_p1;
  logic [DATA_WIDTH-1:0]   data_p1;

  // Returns {overflow, next_count}; a return into a full counter saturates.
  function automatic logic [CREDIT_WIDTH:0] credit_next(
    input logic [CREDIT_WIDTH-1:0] c,
    input logic                    dec,
    input logic                    inc
  );
    logic [CREDIT_WIDTH-1:0] n;
    logic                    ovf;
    n   = c;
    ovf = 1'b0;
    if (dec && !inc) begin
      n = c - CREDIT_WIDTH'(1);
    end else if (inc && !dec) begin
      if (c == FULL) ovf = 1'b1;
      else           n   = c + CREDIT_WIDTH'(1);
    end
    return {ovf, n};
  endfunction

  assign in_ready = (cnt[in_vc] != '0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      logic dec;
      logic inc;
      dec = accept && (in_vc == VC_ID_WIDTH'(v));
      inc = credit_valid && (credit_vc == VC_ID_WIDTH'(v));
      {ovf_hit[v], cnt_nxt[v]} = credit_next(cnt[v], dec, inc);

      state_nxt[v] = state[v];
      perr_hit[v]  = 1'b0;
      if (dec) begin
        if (state[v] == IDLE) begin
          // A stray body/tail on an idle VC is flagged but does not open a packet.
          if (in_head) state_nxt[v] = in_tail ? IDLE : ACTIVE;
          else         perr_hit[v]  = 1'b1;
        end else begin
          perr_hit[v]  = in_head;
          state_nxt[v] = in_tail ? IDLE : ACTIVE;
        end
      end
    end
  end

  // Stage p0 -> p1: register accepted flit onto the link and update VC state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        cnt[v]   <= FULL;
        state[v] <= IDLE;
      end
      vld_p1       <= 1'b0;
      vc_p1        <= '0;
      head_p1      <= 1'b0;
      tail_p1      <= 1'b0;
      data_p1      <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        cnt[v]   <= cnt_nxt[v];
        state[v] <= state_nxt[v];
      end
      vld_p1 <= accept;
      if (accept) begin
        vc_p1   <= in_vc;
        head_p1 <= in_head;
        tail_p1 <= in_tail;
        data_p1 <= in_data;
      end
      err_overflow <= err_overflow | (|ovf_hit);
      err_protocol <= err_protocol | (|perr_hit);
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      credits[v*CREDIT_WIDTH +: CREDIT_WIDTH] = cnt[v];
      vc_busy[v]                              = (state[v] == ACTIVE);
    end
  end

  assign out_valid = vld_p1;
  assign out_vc    = vc_p1;
  assign out_head  = head_p1;
  assign out_tail  = tail_p1;
  assign out_data  = data_p1;

endmodule

// File: tb/tb_vc_credit_sender.sv
// Directed bench for vc_credit_sender: link flits checked by a scoreboard monitor,
// credit/state/error outputs checked against hand-computed values.
`timescale 1ns/1ps

module tb_vc_credit_sender;

  localparam int NV = 4;
  localparam int DW = 32;
  localparam int VW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [VW-1:0]   in_vc;
  logic            in_head;
  logic            in_tail;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            credit_valid;
  logic [VW-1:0]   credit_vc;
  logic            out_valid;
  logic [VW-1:0]   out_vc;
  logic            out_head;
  logic            out_tail;
  logic [DW-1:0]   out_data;
  logic [NV*CW-1:0] credits;
  logic [NV-1:0]   vc_busy;
  logic            err_overflow;
  logic            err_protocol;

  vc_credit_sender #(.NUM_VCS(NV), .BUFFER_DEPTH(8), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail),
    .in_data(in_data), .in_ready(in_ready),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .out_valid(out_valid), .out_vc(out_vc), .out_head(out_head), .out_tail(out_tail),
    .out_data(out_data), .credits(credits), .vc_busy(vc_busy),
    .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [VW+2+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cred(input int v);
    return credits[v*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit expected to be accepted at the next edge and record it.
  task automatic send(input int vc, input logic h, input logic t, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_vc    = VW'(vc);
    in_head  = h;
    in_tail  = t;
    in_data  = d;
    exp_q.push_back({VW'(vc), h, t, d});
    tick();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_vc = '0; in_head = 1'b0; in_tail = 1'b0;
    in_data = '0; credit_valid = 1'b0; credit_vc = '0;

    fork
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_flit", {out_vc, out_head, out_tail, out_data}, '1);
          end else begin
            chk("link_flit", {out_vc, out_head, out_tail, out_data}, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset
    tick(); tick();
    chk("rst_credits", credits, 16'h8888);
    chk("rst_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", vc_busy, 0);
    chk("rst_errs", {err_overflow, err_protocol}, 0);
    reset = 1'b1;
    tick();

    // Drain VC1 with one 8-flit packet
    for (int i = 0; i < 8; i++) send(1, i == 0, i == 7, 32'h100 + i);
    in_valid = 1'b0;
    in_vc    = 2'd1;
    #1;
    chk("drain_cred1", cred(1), 0);
    chk("drain_ready_vc1", in_ready, 0);
    in_vc = 2'd0;
    #1;
    chk("drain_ready_vc0", in_ready, 1);
    chk("drain_busy1", vc_busy[1], 0);

    // Credit returned while VC1 is empty: no same-cycle bypass
    in_valid = 1'b1; in_vc = 2'd1; in_head = 1'b1; in_tail = 1'b1; in_data = 32'h1FF;
    credit_valid = 1'b1; credit_vc = 2'd1;
    #1;
    chk("cr0_ready_same_cycle", in_ready, 0);
    tick();
    credit_valid = 1'b0;
    chk("cr0_cred1", cred(1), 1);
    chk("cr0_ready_next", in_ready, 1);
    send(1, 1'b1, 1'b1, 32'h1FF);
    in_valid = 1'b0;
    chk("cr0_cred1_used", cred(1), 0);

    // VC2 down to 5, then accept + credit in the same cycle
    send(2, 1'b1, 1'b0, 32'h200);
    send(2, 1'b0, 1'b0, 32'h201);
    send(2, 1'b0, 1'b0, 32'h202);
    chk("sim_cred2_pre", cred(2), 5);
    credit_valid = 1'b1; credit_vc = 2'd2;
    send(2, 1'b0, 1'b1, 32'h203);
    credit_valid = 1'b0; in_valid = 1'b0;
    chk("sim_cred2", cred(2), 5);
    chk("sim_out_valid", out_valid, 1);
    chk("sim_busy2", vc_busy[2], 0);

    // Packet FSM on VC3, single-flit and stray body on VC0
    send(3, 1'b1, 1'b0, 32'h300);
    chk("fsm_head_busy3", vc_busy[3], 1);
    send(3, 1'b0, 1'b0, 32'h301);
    chk("fsm_body_busy3", vc_busy[3], 1);
    send(3, 1'b0, 1'b1, 32'h302);
    chk("fsm_tail_busy3", vc_busy[3], 0);
    send(0, 1'b1, 1'b1, 32'h0AA);
    chk("fsm_single_busy0", vc_busy[0], 0);
    chk("fsm_single_noerr", err_protocol, 0);
    send(0, 1'b0, 1'b0, 32'h0BB);
    in_valid = 1'b0;
    chk("fsm_stray_err", err_protocol, 1);
    chk("fsm_stray_busy0", vc_busy[0], 0);
    chk("fsm_cred0", cred(0), 6);

    // Refill VC0, then overflow it
    credit_valid = 1'b1; credit_vc = 2'd0;
    tick(); tick();
    chk("ovf_cred0_full", cred(0), 8);
    chk("ovf_not_yet", err_overflow, 0);
    tick();
    credit_valid = 1'b0;
    chk("ovf_cred0_sat", cred(0), 8);
    chk("ovf_flag", err_overflow, 1);

    // Reset while VC3 is mid-packet with 3 credits
    send(3, 1'b1, 1'b0, 32'h310);
    send(3, 1'b0, 1'b0, 32'h311);
    chk("mid_cred3", cred(3), 3);
    chk("mid_busy3", vc_busy[3], 1);
    in_head = 1'b0; in_tail = 1'b0; in_data = 32'h312;
    reset = 1'b0;
    tick();
    chk("mrst_credits", credits, 16'h8888);
    chk("mrst_busy", vc_busy, 0);
    chk("mrst_errs", {err_overflow, err_protocol}, 0);
    chk("mrst_out_valid", out_valid, 0);
    reset = 1'b1;
    in_valid = 1'b0;
    tick();

    send(2, 1'b1, 1'b1, 32'hABC);
    in_valid = 1'b0;
    chk("post_cred2", cred(2), 7);
    tick(); tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
